lsq_dmem_arbiter: RTL and testbench
===================================

# lsq_dmem_arbiter

Sequences the single data-memory port between two requesters: LSQ-issued loads and retirement-committed stores. Holds one memory transaction in flight, returns load data to the LSQ/CDB side, and acknowledges committed stores. Stores have priority, with a starvation limit that guarantees loads forward progress. Sits between the LSQ issue/retire outputs and the data memory.

## Interface
- STARVE_LIMIT, 4, number of consecutive store grants with a load waiting before the load is forced to win (1..15)
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- ld_valid  in  1  load request present
- ld_ready  out  1  load accepted this cycle when ld_valid & ld_ready
- ld_pc  in  32  PC tag of load
- ld_addr  in  32  computed load address
- st_valid  in  1  committed store present
- st_ready  out  1  store accepted when st_valid & st_ready
- st_pc  in  32  PC tag of store
- st_addr  in  32  store address
- st_data  in  32  store data
- flush  in  1  kill all uncompleted loads (branch mispredict); stores unaffected
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  transaction complete (reads and writes); earliest the cycle after mem_gnt
- mem_rdata  in  32  read data, valid with mem_rvalid
- ld_resp_valid  out  1  one-cycle load-completion pulse
- ld_resp_pc  out  32  PC of completed load
- ld_resp_data  out  32  load data
- st_done  out  1  one-cycle store-completion pulse
- st_done_pc  out  32  PC of completed store
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE -> REQ (on accept) -> WAIT (on mem_gnt) -> IDLE (on mem_rvalid, response registered).
- IDLE: ready driven combinationally to the winner only; the other ready is 0. In REQ and WAIT, both readies are 0.
- Arbitration in IDLE: only one valid -> it wins. Both valid -> store wins unless starve_cnt == STARVE_LIMIT, then load wins.
- starve_cnt: increments on a store accept while ld_valid = 1, saturating at STARVE_LIMIT. Cleared on a load accept, or in any IDLE cycle with ld_valid = 0.
- On accept, register op, pc, addr, and wdata (stores). mem_* outputs come from registers and stay stable through REQ.
- mem_rvalid in WAIT:
  - Load: ld_resp_valid = 1 next cycle, with the registered pc and mem_rdata captured at rvalid.
  - Store: st_done = 1 next cycle, with st_done_pc.
- flush:
  - In IDLE: ld_ready forced to 0 that cycle.
  - In REQ or WAIT holding a load: set the killed flag. The request still completes on the bus (mem_req is never withdrawn), and the response pulse is suppressed.
  - Holding a store: no effect.
- mem_rvalid or mem_gnt outside the expected state is ignored.

## Timing
- Reset values: ld_ready = st_ready = 0 (during reset), mem_req = 0, mem_we = 0, mem_addr = mem_wdata = 0, ld_resp_valid = 0, ld_resp_pc = ld_resp_data = 0, st_done = 0, st_done_pc = 0, busy = 0, starve_cnt = 0, killed = 0, state = IDLE.
- Accept at cycle N -> mem_req = 1 from N+1. Minimum path: gnt at N+1, rvalid at N+2, response pulse at N+3.
- The response-pulse cycle is already IDLE, so a new accept can occur in it. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- Response pulses last exactly 1 cycle. The pc and data outputs hold their value until the next response.
- Reset mid-transaction: return immediately to IDLE; the in-flight transaction is abandoned with no response pulse.

## Structure
- Shared package lsq_pkg:
  - dmem_state_t enum (IDLE, REQ, WAIT).
  - XLEN = 32.
  - Op encoding: MEM_LD = 0, MEM_ST = 1, matching the LSQ op bit.
- No sub-module; the arbiter, starvation counter, and FSM are a single module.

## Test plan
- Single load, ld_addr = 0x100, gnt at N+1, rvalid at N+2 with rdata = 0xDEADBEEF -> ld_resp_valid at N+3, pc = 0x8, data = 0xDEADBEEF; mem_we = 0 throughout.
- Single store, addr = 0x200, data = 0x12345678, gnt delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles; st_done one cycle after rvalid.
- ld_valid and st_valid held high continuously, STARVE_LIMIT = 4 -> grant sequence S, S, S, S, L, S, S, S, S, L.
- Load accepted, flush asserted during WAIT -> the memory read still completes, no ld_resp_valid pulse, busy drops after rvalid.
- flush in IDLE with ld_valid = 1 and st_valid = 0 -> ld_ready = 0 that cycle, and the load is accepted the next cycle.
- rstn asserted while in WAIT -> all outputs go to their reset values immediately; a late mem_rvalid after reset produces no pulse.

Source files
------------

// File: rtl/lsq_pkg.sv
// ---------------------------------------------------------------------------
// lsq_pkg
// Shared definitions for the LSQ data-memory arbiter: data width, the
// arbiter FSM state type, the load/store op encoding used by the LSQ, and a
// small saturating-increment helper for the starvation counter.
// ---------------------------------------------------------------------------
package lsq_pkg;

    localparam int XLEN = 32;

    // Op bit as carried by the LSQ.
    localparam logic MEM_LD = 1'b0;
    localparam logic MEM_ST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dmem_state_t;

    // Increment v by one, never exceeding lim.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsq_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// lsq_dmem_arbiter_if
// Bundles the load request, store request, data-memory and response signals
// of the LSQ data-memory arbiter.
//   slave  : the arbiter's view (takes requests, drives memory + responses)
//   master : the surrounding LSQ / memory environment's view
// ---------------------------------------------------------------------------
interface lsq_dmem_arbiter_if;
    import lsq_pkg::*;

    // load request side
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_pc;
    logic [XLEN-1:0] ld_addr;
    // store request side
    logic            st_valid;
    logic            st_ready;
    logic [XLEN-1:0] st_pc;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;
    // branch-mispredict kill of loads
    logic            flush;
    // data-memory port
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    // completions
    logic            ld_resp_valid;
    logic [XLEN-1:0] ld_resp_pc;
    logic [XLEN-1:0] ld_resp_data;
    logic            st_done;
    logic [XLEN-1:0] st_done_pc;
    logic            busy;

    modport slave (
        input  ld_valid, ld_pc, ld_addr,
        input  st_valid, st_pc, st_addr, st_data,
        input  flush,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ld_ready, st_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ld_resp_valid, ld_resp_pc, ld_resp_data,
        output st_done, st_done_pc, busy
    );

    modport master (
        output ld_valid, ld_pc, ld_addr,
        output st_valid, st_pc, st_addr, st_data,
        output flush,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ld_ready, st_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ld_resp_valid, ld_resp_pc, ld_resp_data,
        input  st_done, st_done_pc, busy
    );

endinterface

// File: rtl/lsq_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// lsq_dmem_arbiter
// Shares the single data-memory port between LSQ loads and committed stores.
// One transaction in flight: IDLE -> REQ (accepted) -> WAIT (granted) ->
// IDLE (completed, response pulse registered). Stores win arbitration unless
// a waiting load has lost STARVE_LIMIT consecutive times. flush kills an
// in-flight load's response without withdrawing the bus request.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : lsq_dmem_arbiter_if.slave (requests, memory port, completions)
// ---------------------------------------------------------------------------
module lsq_dmem_arbiter
    import lsq_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    lsq_dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    dmem_state_t     state_r;
    logic            op_r;
    logic [XLEN-1:0] pc_r;
    logic            killed_r;
    logic [3:0]      starve_cnt_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [XLEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;
    logic            ld_resp_valid_r;
    logic [XLEN-1:0] ld_resp_pc_r;
    logic [XLEN-1:0] ld_resp_data_r;
    logic            st_done_r;
    logic [XLEN-1:0] st_done_pc_r;
    logic            busy_r;

    logic            ld_eff_s;
    logic            ld_win_s;
    logic            st_win_s;

    // Arbitration: only in IDLE and out of reset; a flushed load cannot win.
    always_comb begin
        ld_win_s = 1'b0;
        st_win_s = 1'b0;
        ld_eff_s = bus.ld_valid & ~bus.flush;
        if (rstn && (state_r == IDLE)) begin
            if (bus.st_valid && ld_eff_s) begin
                if (starve_cnt_r == LIMIT) begin
                    ld_win_s = 1'b1;
                end else begin
                    st_win_s = 1'b1;
                end
            end else if (bus.st_valid) begin
                st_win_s = 1'b1;
            end else if (ld_eff_s) begin
                ld_win_s = 1'b1;
            end else begin
                ld_win_s = 1'b0;
                st_win_s = 1'b0;
            end
        end else begin
            ld_win_s = 1'b0;
            st_win_s = 1'b0;
        end
    end

    // Starvation counter: counts store wins over a waiting load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            if (ld_win_s || !bus.ld_valid) begin
                starve_cnt_r <= 4'd0;
            end else if (st_win_s) begin
                starve_cnt_r <= sat_inc4(starve_cnt_r, LIMIT);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Transaction FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r         <= IDLE;
            op_r            <= MEM_LD;
            pc_r            <= '0;
            killed_r        <= 1'b0;
            mem_req_r       <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= '0;
            mem_wdata_r     <= '0;
            ld_resp_valid_r <= 1'b0;
            ld_resp_pc_r    <= '0;
            ld_resp_data_r  <= '0;
            st_done_r       <= 1'b0;
            st_done_pc_r    <= '0;
            busy_r          <= 1'b0;
        end else begin
            // completion pulses are single-cycle
            ld_resp_valid_r <= 1'b0;
            st_done_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (st_win_s) begin
                        state_r     <= REQ;
                        busy_r      <= 1'b1;
                        mem_req_r   <= 1'b1;
                        killed_r    <= 1'b0;
                        op_r        <= MEM_ST;
                        mem_we_r    <= 1'b1;
                        pc_r        <= bus.st_pc;
                        mem_addr_r  <= bus.st_addr;
                        mem_wdata_r <= bus.st_data;
                    end else if (ld_win_s) begin
                        state_r     <= REQ;
                        busy_r      <= 1'b1;
                        mem_req_r   <= 1'b1;
                        killed_r    <= 1'b0;
                        op_r        <= MEM_LD;
                        mem_we_r    <= 1'b0;
                        pc_r        <= bus.ld_pc;
                        mem_addr_r  <= bus.ld_addr;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.flush && (op_r == MEM_LD)) begin
                        killed_r <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush && (op_r == MEM_LD)) begin
                        killed_r <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (op_r == MEM_ST) begin
                            st_done_r    <= 1'b1;
                            st_done_pc_r <= pc_r;
                        end else if (!(killed_r || bus.flush)) begin
                            // a flush arriving with rvalid also kills the load
                            ld_resp_valid_r <= 1'b1;
                            ld_resp_pc_r    <= pc_r;
                            ld_resp_data_r  <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_ready      = ld_win_s;
    assign bus.st_ready      = st_win_s;
    assign bus.mem_req       = mem_req_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_wdata     = mem_wdata_r;
    assign bus.ld_resp_valid = ld_resp_valid_r;
    assign bus.ld_resp_pc    = ld_resp_pc_r;
    assign bus.ld_resp_data  = ld_resp_data_r;
    assign bus.st_done       = st_done_r;
    assign bus.st_done_pc    = st_done_pc_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_lsq_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsq_dmem_arbiter
// Drives directed scenarios followed by randomized traffic into
// lsq_dmem_arbiter and compares every cycle against a transaction-level
// reference model (one outstanding record plus a starvation count).
// ---------------------------------------------------------------------------
module tb_lsq_dmem_arbiter;

    localparam int LIMIT = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    lsq_dmem_arbiter_if bus();

    lsq_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model: one outstanding transaction record
    bit          m_has;
    bit          m_granted;
    bit          m_st;
    bit          m_killed;
    logic [31:0] m_pc;
    int          m_starve;
    // expected registered outputs
    bit          e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    bit          e_ldv;
    logic [31:0] e_ldpc;
    logic [31:0] e_lddata;
    bit          e_std;
    logic [31:0] e_stpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_has = 0; m_granted = 0; m_st = 0; m_killed = 0; m_pc = '0; m_starve = 0;
        e_we = 0; e_addr = '0; e_wdata = '0;
        e_ldv = 0; e_ldpc = '0; e_lddata = '0; e_std = 0; e_stpc = '0;
    endtask

    task automatic check_regs();
        chk("mem_req",       32'(bus.mem_req),       32'(m_has && !m_granted));
        chk("mem_we",        32'(bus.mem_we),        32'(e_we));
        chk("mem_addr",      bus.mem_addr,           e_addr);
        chk("mem_wdata",     bus.mem_wdata,          e_wdata);
        chk("ld_resp_valid", 32'(bus.ld_resp_valid), 32'(e_ldv));
        chk("ld_resp_pc",    bus.ld_resp_pc,         e_ldpc);
        chk("ld_resp_data",  bus.ld_resp_data,       e_lddata);
        chk("st_done",       32'(bus.st_done),       32'(e_std));
        chk("st_done_pc",    bus.st_done_pc,         e_stpc);
        chk("busy",          32'(bus.busy),          32'(m_has));
    endtask

    task automatic drive_idle();
        bus.ld_valid = 0; bus.ld_pc = '0; bus.ld_addr = '0;
        bus.st_valid = 0; bus.st_pc = '0; bus.st_addr = '0; bus.st_data = '0;
        bus.flush = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    // One clock: called just after a falling edge, returns just after the next.
    // grant reports what the DUT accepted (0 none, 1 load, 2 store).
    task automatic step(input bit lv, input logic [31:0] lpc, input logic [31:0] laddr,
                        input bit sv, input logic [31:0] spc, input logic [31:0] saddr,
                        input logic [31:0] sdata, input bit fl, input bit gnt,
                        input bit rv, input logic [31:0] rdata, output int grant);
        int win;
        bit idle;
        bus.ld_valid = lv; bus.ld_pc = lpc; bus.ld_addr = laddr;
        bus.st_valid = sv; bus.st_pc = spc; bus.st_addr = saddr; bus.st_data = sdata;
        bus.flush = fl; bus.mem_gnt = gnt; bus.mem_rvalid = rv; bus.mem_rdata = rdata;
        #1;
        idle = !m_has;
        win  = 0;
        if (idle) begin
            if (sv && !(lv && !fl && m_starve == LIMIT)) win = 2;
            else if (lv && !fl) win = 1;
        end
        chk("ld_ready", 32'(bus.ld_ready), 32'(win == 1));
        chk("st_ready", 32'(bus.st_ready), 32'(win == 2));
        grant = bus.ld_ready ? 1 : (bus.st_ready ? 2 : 0);

        e_ldv = 0;
        e_std = 0;
        if (win != 0) begin
            m_has = 1; m_granted = 0; m_killed = 0;
            m_st   = (win == 2);
            m_pc   = m_st ? spc : lpc;
            e_addr = m_st ? saddr : laddr;
            e_we   = m_st;
            if (m_st) e_wdata = sdata;
        end else if (m_has) begin
            if (fl && !m_st) m_killed = 1;
            if (!m_granted) begin
                if (gnt) m_granted = 1;
            end else if (rv) begin
                m_has = 0;
                if (m_st) begin
                    e_std = 1; e_stpc = m_pc;
                end else if (!m_killed) begin
                    e_ldv = 1; e_ldpc = m_pc; e_lddata = rdata;
                end
            end
        end
        if (win == 1) m_starve = 0;
        else if (idle && !lv) m_starve = 0;
        else if (win == 2) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;

        @(negedge clk);
        check_regs();
    endtask

    task automatic check_reset_outputs();
        chk("rst_ld_ready",      32'(bus.ld_ready),      32'd0);
        chk("rst_st_ready",      32'(bus.st_ready),      32'd0);
        chk("rst_mem_req",       32'(bus.mem_req),       32'd0);
        chk("rst_mem_we",        32'(bus.mem_we),        32'd0);
        chk("rst_mem_addr",      bus.mem_addr,           32'd0);
        chk("rst_mem_wdata",     bus.mem_wdata,          32'd0);
        chk("rst_ld_resp_valid", 32'(bus.ld_resp_valid), 32'd0);
        chk("rst_ld_resp_pc",    bus.ld_resp_pc,         32'd0);
        chk("rst_ld_resp_data",  bus.ld_resp_data,       32'd0);
        chk("rst_st_done",       32'(bus.st_done),       32'd0);
        chk("rst_st_done_pc",    bus.st_done_pc,         32'd0);
        chk("rst_busy",          32'(bus.busy),          32'd0);
    endtask

    initial begin
        int g;
        logic [9:0] seq;

        drive_idle();
        model_reset();
        // power-on reset with both requests present: readies must stay low
        bus.ld_valid = 1; bus.st_valid = 1;
        #2 rstn = 1'b0;
        #2 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;

        // single load: pc 0x8, addr 0x100, minimum latency
        step(1, 32'h8, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("load_grant", 32'(g), 32'd1);
        chk("load_mem_addr", bus.mem_addr, 32'h100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, g);
        chk("load_resp_valid", 32'(bus.ld_resp_valid), 32'd1);
        chk("load_resp_pc",    bus.ld_resp_pc,         32'h8);
        chk("load_resp_data",  bus.ld_resp_data,       32'hDEADBEEF);
        chk("load_mem_we",     32'(bus.mem_we),        32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("load_pulse_1cyc", 32'(bus.ld_resp_valid), 32'd0);
        chk("load_pc_held",    bus.ld_resp_pc,         32'h8);

        // single store, grant delayed three cycles
        step(0, 0, 0, 1, 32'h20, 32'h200, 32'h12345678, 0, 0, 0, 0, g);
        chk("store_grant", 32'(g), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("store_req_held",  32'(bus.mem_req), 32'd1);
            chk("store_addr_held", bus.mem_addr,     32'h200);
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        end
        chk("store_req_4th",   32'(bus.mem_req), 32'd1);
        chk("store_wdata",     bus.mem_wdata,    32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, g);
        chk("store_done",    32'(bus.st_done), 32'd1);
        chk("store_done_pc", bus.st_done_pc,   32'h20);

        // both held valid: expect S,S,S,S,L,S,S,S,S,L
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h1000 + 32'(i), 32'h400, 1, 32'h2000 + 32'(i), 32'h500, 32'(i), 0, 0, 0, 0, g);
            chk("starve_some_grant", 32'(g != 0), 32'd1);
            seq[i] = (g == 1);
            step(1, 32'h1000, 32'h400, 1, 32'h2000, 32'h500, 0, 0, 1, 0, 0, g);
            step(1, 32'h1000, 32'h400, 1, 32'h2000, 32'h500, 0, 0, 0, 1, 32'hA5A5_0000 + 32'(i), g);
        end
        chk("starve_sequence", 32'(seq), 32'h210);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // flush during WAIT kills the load response
        step(1, 32'h40, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, g);
        chk("flush_wait_busy", 32'(bus.busy), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, g);
        chk("flush_no_resp", 32'(bus.ld_resp_valid), 32'd0);
        chk("flush_busy_low", 32'(bus.busy), 32'd0);
        chk("flush_data_kept", bus.ld_resp_data, 32'hA5A5_0009);

        // flush in IDLE blocks the load for that cycle only
        step(1, 32'h60, 32'h600, 0, 0, 0, 0, 1, 0, 0, 0, g);
        chk("flush_idle_block", 32'(g), 32'd0);
        step(1, 32'h60, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, g);
        chk("flush_idle_next", 32'(g), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, g);

        // reset while in WAIT, then a late rvalid
        #2 bus.ld_valid = 1; bus.st_valid = 1; rstn = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, g);
        chk("late_rvalid_no_resp", 32'(bus.ld_resp_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
